instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 156 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them to instruction memory and holds the CPU while loading.
module instr_mem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        checksum_o
);

  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned WordW = 32;
  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } stateT;

  stateT state;
  stateT nextState;

  logic [ADDR_W-1:0] wordIdx,   wordIdxN;
  logic [1:0]        byteCnt,   byteCntN;
  logic [WordW-1:0]  wordBuf,   wordBufN;
  logic [CntW-1:0]   wordCount, wordCountN;
  logic [ByteW-1:0]  checksumN;
  logic [ADDR_W-1:0] memWrAddrN;
  logic [WordW-1:0]  memWrDataN;
  logic              errN;
  logic              byteReadyN;
  logic              memWrEnN;
  logic              cpuHoldN;
  logic              busyN;
  logic              doneN;

  logic byteAccept;
  logic legalCount;
  logic lastWord;

  assign byteAccept = byte_valid_i && byte_ready_o;
  assign legalCount = (word_count_i != '0) && (word_count_i <= CntW'(DEPTH));
  assign lastWord   = ({1'b0, wordIdx} == (wordCount - CntW'(1)));

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wordIdx       <= '0;
      byteCnt       <= '0;
      wordBuf       <= '0;
      wordCount     <= '0;
      checksum_o    <= '0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
      err_o         <= 1'b0;
      byte_ready_o  <= 1'b0;
      mem_wr_en_o   <= 1'b0;
      cpu_hold_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state         <= nextState;
      wordIdx       <= wordIdxN;
      byteCnt       <= byteCntN;
      wordBuf       <= wordBufN;
      wordCount     <= wordCountN;
      checksum_o    <= checksumN;
      mem_wr_addr_o <= memWrAddrN;
      mem_wr_data_o <= memWrDataN;
      err_o         <= errN;
      byte_ready_o  <= byteReadyN;
      mem_wr_en_o   <= memWrEnN;
      cpu_hold_o    <= cpuHoldN;
      busy_o        <= busyN;
      done_o        <= doneN;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start_i && legalCount) nextState = COLLECT;
      COLLECT: if (byteAccept && (byteCnt == 2'd3)) nextState = WRITE;
      WRITE:   nextState = lastWord ? DONE : COLLECT;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath updates and next values of the registered outputs
  always_comb begin
    wordIdxN   = wordIdx;
    byteCntN   = byteCnt;
    wordBufN   = wordBuf;
    wordCountN = wordCount;
    checksumN  = checksum_o;
    memWrAddrN = mem_wr_addr_o;
    memWrDataN = mem_wr_data_o;
    errN       = err_o;

    unique case (state)
      IDLE: begin
        if (start_i && legalCount) begin
          wordIdxN   = '0;
          byteCntN   = '0;
          checksumN  = '0;
          errN       = 1'b0;
          wordCountN = word_count_i;
        end else if (start_i) begin
          errN = 1'b1;
        end
      end
      COLLECT: begin
        if (byteAccept) begin
          wordBufN[{byteCnt, 3'b000} +: ByteW] = byte_data_i;
          checksumN = checksum_o ^ byte_data_i;
          byteCntN  = byteCnt + 2'd1;
        end
      end
      WRITE: begin
        if (!lastWord) wordIdxN = wordIdx + ADDR_W'(1);
      end
      default: ;
    endcase

    // Write address/data are loaded only on entry to WRITE so they hold otherwise
    if ((state == COLLECT) && (nextState == WRITE)) begin
      memWrAddrN = wordIdx;
      memWrDataN = wordBufN;
    end

    byteReadyN = (nextState == COLLECT);
    memWrEnN   = (nextState == WRITE);
    doneN      = (nextState == DONE);
    busyN      = (nextState != IDLE);
    cpuHoldN   = (nextState != IDLE);
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a word/checksum
// model built directly from the byte stream.
module tb_instr_mem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [AW:0]   word_count_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          mem_wr_en_o;
  logic [AW-1:0] mem_wr_addr_o;
  logic [31:0]   mem_wr_data_o;
  logic          cpu_hold_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [7:0]    checksum_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0]    txBytes[$];
  logic [31:0]   expWords[$];
  logic [AW-1:0] holdAddr;
  logic [31:0]   holdData;
  logic [51:0]   allOut;

  assign allOut = {byte_ready_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o,
                   cpu_hold_o, busy_o, done_o, err_o, checksum_o};

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .word_count_i(word_count_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  task automatic fillRandom(input int count);
    txBytes = {};
    for (int i = 0; i < 4 * count; i++) txBytes.push_back(8'($urandom));
  endtask

  // Runs one load of txBytes; stopAfter>0 returns right after that many writes
  task automatic runLoad(input int count, input int pct, input bit pulseStart,
                         input int stopAfter);
    int idx = 0;
    int nWr = 0;
    int busyCyc = 0;
    int nDone = 0;
    int budget = 60 * count + 20;
    bit gotDone = 1'b0;
    bit rdy;
    bit v;
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    expWords = {};
    for (int wi = 0; wi < count; wi++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        w[8*k +: 8] = txBytes[4*wi + k];
        cs = cs ^ txBytes[4*wi + k];
      end
      expWords.push_back(w);
    end

    @(negedge clk);
    start_i = 1'b1; word_count_i = 7'(count); byte_valid_i = 1'b0;
    @(posedge clk);
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start_i = pulseStart && ($urandom_range(3) == 0);
      word_count_i = 7'($urandom);
      if (busy_o) busyCyc++;
      checks++;
      if ({cpu_hold_o, busy_o, err_o} !== 3'b110) begin
        failures++;
        $display("FAIL load_flags: hold/busy/err got %b required 110", {cpu_hold_o, busy_o, err_o});
      end
      checks++;
      if (byte_ready_o && mem_wr_en_o) begin
        failures++;
        $display("FAIL ready_in_write: byte_ready_o got 1 required 0");
      end
      checks++;
      if (mem_wr_en_o) begin
        if (nWr >= count) begin
          failures++;
          $display("FAIL extra_write: write %0d got, only %0d required", nWr, count);
        end else if ({mem_wr_addr_o, mem_wr_data_o} !== {AW'(nWr), expWords[nWr]}) begin
          failures++;
          $display("FAIL write_word: got addr %0d data %h required addr %0d data %h",
                   mem_wr_addr_o, mem_wr_data_o, nWr, expWords[nWr]);
        end
        if (nWr < count) begin
          holdAddr = AW'(nWr);
          holdData = expWords[nWr];
        end
        nWr++;
      end else if ({mem_wr_addr_o, mem_wr_data_o} !== {holdAddr, holdData}) begin
        failures++;
        $display("FAIL write_hold: got addr %0d data %h required addr %0d data %h",
                 mem_wr_addr_o, mem_wr_data_o, holdAddr, holdData);
      end
      if (done_o) begin
        nDone++;
        gotDone = 1'b1;
      end
      if (gotDone || (stopAfter > 0 && nWr == stopAfter)) break;
      rdy = byte_ready_o;
      v = (idx < 4 * count) && ($urandom_range(99) < pct);
      byte_valid_i = v;
      byte_data_i = v ? txBytes[idx] : 8'($urandom);
      @(posedge clk);
      if (v && rdy) idx++;
    end
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    if (stopAfter > 0) return;

    checks++;
    if (!gotDone) begin
      failures++;
      $display("FAIL load_timeout: done_o got 0 within %0d cycles required 1", budget);
    end
    checks++;
    if (nWr != count) begin
      failures++;
      $display("FAIL write_count: got %0d required %0d", nWr, count);
    end
    checks++;
    if ((pct >= 100) ? (busyCyc != 5 * count + 1) : (busyCyc < 5 * count + 1)) begin
      failures++;
      $display("FAIL load_cycles: got %0d required %0d (min when throttled)", busyCyc, 5 * count + 1);
    end
    @(negedge clk);
    checks++;
    if ({cpu_hold_o, busy_o, done_o, byte_ready_o} !== 4'b0000) begin
      failures++;
      $display("FAIL after_done: hold/busy/done/ready got %b required 0000",
               {cpu_hold_o, busy_o, done_o, byte_ready_o});
    end
    // Idle with noise on the byte stream: nothing may change
    for (int i = 0; i < 3; i++) begin
      byte_valid_i = 1'($urandom);
      byte_data_i = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({checksum_o, mem_wr_en_o, done_o} !== {cs, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL checksum_hold: got cs %h wr %b done %b required cs %h wr 0 done 0",
                 checksum_o, mem_wr_en_o, done_o, cs);
      end
    end
    byte_valid_i = 1'b0;
    checks++;
    if (nDone != 1) begin
      failures++;
      $display("FAIL done_pulses: got %0d required 1", nDone);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; word_count_i = '0;
    byte_valid_i = 1'b0; byte_data_i = '0;
    holdAddr = '0; holdData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (allOut !== 52'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", allOut);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_word;
    txBytes = {8'h13, 8'h00, 8'h50, 8'h00};
    runLoad(1, 100, 1'b0, 0);
    checks++;
    if (checksum_o !== 8'h43) begin
      failures++;
      $display("FAIL single_checksum: got %h required 43", checksum_o);
    end
  endtask

  task automatic test_full_depth;
    fillRandom(DEPTH);
    runLoad(DEPTH, 100, 1'b0, 0);
  endtask

  task automatic test_bad_count;
    int bad[3] = '{0, DEPTH + 1, 127};
    foreach (bad[i]) begin
      @(negedge clk);
      start_i = 1'b1; word_count_i = 7'(bad[i]);
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({err_o, busy_o, mem_wr_en_o, cpu_hold_o, byte_ready_o} !== 5'b10000) begin
          failures++;
          $display("FAIL bad_count_%0d: err/busy/wr/hold/ready got %b required 10000",
                   bad[i], {err_o, busy_o, mem_wr_en_o, cpu_hold_o, byte_ready_o});
        end
        @(negedge clk);
      end
    end
    fillRandom(1);
    runLoad(1, 100, 1'b0, 0);
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared: got %b required 0", err_o);
    end
  endtask

  task automatic test_random_valid;
    fillRandom(2);
    runLoad(2, 50, 1'b1, 0);
  endtask

  task automatic test_reset_mid_load;
    fillRandom(3);
    runLoad(3, 100, 1'b0, 2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (allOut !== 52'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %h required 0", allOut);
    end
    rst_n = 1'b1;
    holdAddr = '0; holdData = '0;
    for (int c = 0; c < 10; c++) begin
      byte_valid_i = 1'($urandom);
      byte_data_i = 8'($urandom);
      @(negedge clk);
      checks++;
      if (allOut !== 52'h0) begin
        failures++;
        $display("FAIL aborted_idle: got %h required 0", allOut);
      end
    end
    byte_valid_i = 1'b0;
    fillRandom(3);
    runLoad(3, 70, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    int n;
    for (int i = 0; i < 5; i++) begin
      n = $urandom_range(1, 8);
      fillRandom(n);
      runLoad(n, $urandom_range(30, 100), 1'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_depth();
    test_bad_count();
    test_random_valid();
    test_reset_mid_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
